// File: rtl/scan_pe_pipe_if.sv
// rtl/scan_pe_pipe_if.sv - operation/result handshake bundle for the SCAN processing element
interface scan_pe_pipe_if #(
    parameter int P  = 64,
    parameter int Q  = 6,
    parameter int SW = $clog2($clog2(P) + 1)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [SW-1:0]    size_log;
    logic             frozen0;
    logic             frozen1;
    logic [P*Q-1:0]   a_l;
    logic [P*Q-1:0]   a_r;
    logic [P*Q-1:0]   b_l;
    logic [P*Q-1:0]   b_r;
    logic             out_valid;
    logic             out_ready;
    logic [2*P*Q-1:0] o;
    logic [2*P*Q-1:0] o_prev;
    logic [Q-1:0]     u0;
    logic [Q-1:0]     u1;
    logic             sat_flag;
    logic             op_err;

    // Scheduler side: issues operations, consumes results
    modport master (
        output in_valid, op, size_log, frozen0, frozen1, a_l, a_r, b_l, b_r, out_ready,
        input  in_ready, out_valid, o, o_prev, u0, u1, sat_flag, op_err
    );

    // PE side
    modport slave (
        input  in_valid, op, size_log, frozen0, frozen1, a_l, a_r, b_l, b_r, out_ready,
        output in_ready, out_valid, o, o_prev, u0, u1, sat_flag, op_err
    );
endinterface

// File: rtl/scan_pe_pipe.sv
// rtl/scan_pe_pipe.sv - elastic min-sum / saturating-add processing element for SCAN decoding
module scan_pe_pipe #(
    parameter int P    = 64,
    parameter int Q    = 6,
    parameter int PIPE = 1,
    parameter int SW   = $clog2($clog2(P) + 1)
) (
    input logic           clk,
    input logic           rst,
    scan_pe_pipe_if.slave bus
);
    localparam int LOGP = $clog2(P);

    localparam logic [2:0] OP_L_LEFT   = 3'd0;
    localparam logic [2:0] OP_L_RIGHT  = 3'd1;
    localparam logic [2:0] OP_B_UPDATE = 3'd2;
    localparam logic [2:0] OP_BOTTOM   = 3'd3;

    // Q-bit constants: +MAX, the asymmetric minimum, and -MAX
    localparam logic [Q-1:0] MAXV    = {1'b0, {(Q-1){1'b1}}};
    localparam logic [Q-1:0] MINV    = {1'b1, {(Q-1){1'b0}}};
    localparam logic [Q-1:0] NEG_MAX = {1'b1, {(Q-2){1'b0}}, 1'b1};
    // Saturation bounds at the Q+1-bit sum width
    localparam logic signed [Q:0] SUM_HI = {2'b00, {(Q-1){1'b1}}};
    localparam logic signed [Q:0] SUM_LO = {2'b11, {(Q-2){1'b0}}, 1'b1};

    // Stage-1 product: masked operands, saturated partial sums and min-sum terms
    typedef struct packed {
        logic [2:0]          op;
        logic                fz0;
        logic                fz1;
        logic                sat;
        logic [P-1:0][Q-1:0] al;
        logic [P-1:0][Q-1:0] ar;
        logic [P-1:0][Q-1:0] bl;
        logic [P-1:0][Q-1:0] br;
        logic [P-1:0][Q-1:0] s1;
        logic [P-1:0][Q-1:0] m;
    } st1_t;

    // The most negative code is folded onto -MAX so negation never overflows
    function automatic logic [Q-1:0] norm(input logic [Q-1:0] x);
        return (x == MINV) ? NEG_MAX : x;
    endfunction

    // Returns {saturated, clamped sum}
    function automatic logic [Q:0] sat_add(input logic [Q-1:0] x, input logic [Q-1:0] y);
        logic signed [Q:0] s;
        s = $signed({x[Q-1], x}) + $signed({y[Q-1], y});
        if (s > SUM_HI) return {1'b1, MAXV};
        if (s < SUM_LO) return {1'b1, NEG_MAX};
        return {1'b0, s[Q-1:0]};
    endfunction

    // Min-sum kernel: sign(x)*sign(y)*min(|x|,|y|), zero counts as positive
    function automatic logic [Q-1:0] fmin(input logic [Q-1:0] x, input logic [Q-1:0] y);
        logic [Q-1:0] ax;
        logic [Q-1:0] ay;
        logic [Q-1:0] mn;
        ax = x[Q-1] ? -x : x;
        ay = y[Q-1] ? -y : y;
        mn = (ax < ay) ? ax : ay;
        return (x[Q-1] ^ y[Q-1]) ? -mn : mn;
    endfunction

    st1_t                st1_d;
    st1_t                st1_q;
    logic                v1;
    logic                v2;
    logic                ld1;
    logic                ld2;
    logic [SW-1:0]       eff_size;
    logic [Q-1:0]        r00_in;
    logic [Q-1:0]        r01_in;
    logic [Q-1:0]        r00_q;
    logic [Q-1:0]        r01_q;
    logic [Q:0]          rs1;
    logic [Q:0]          rs2;
    logic [P-1:0][Q-1:0] a_n;
    logic [P-1:0][Q-1:0] b_n;
    logic [Q-1:0]        u0_n;
    logic [Q-1:0]        u1_n;
    logic                sat_n;
    logic [2*P*Q-1:0]    o_q;
    logic [2*P*Q-1:0]    o_prev_q;
    logic [Q-1:0]        u0_q;
    logic [Q-1:0]        u1_q;
    logic                sat_q;
    logic                err_q;

    assign eff_size = (bus.size_log > SW'(LOGP)) ? SW'(LOGP) : bus.size_log;
    assign r00_in   = bus.frozen0 ? MAXV : '0;
    assign r01_in   = bus.frozen1 ? MAXV : '0;
    assign r00_q    = st1_q.fz0 ? MAXV : '0;
    assign r01_q    = st1_q.fz1 ? MAXV : '0;

    // Output stage advances when empty or when the consumer takes its result
    assign ld2          = !v2 || bus.out_ready;
    assign bus.in_ready = !rst && ld1;

    // Stage-1 datapath: operand masking, partial sums and min-sum terms
    always_comb begin
        st1_d     = '0;
        rs1       = '0;
        st1_d.op  = bus.op;
        st1_d.fz0 = bus.frozen0;
        st1_d.fz1 = bus.frozen1;
        // Inactive lanes, non-zero lanes of BOTTOM and reserved ops see zero operands,
        // which makes every later term zero and keeps them out of the flag
        for (int i = 0; i < P; i++) begin
            if (!bus.op[2] && (i < (1 << eff_size)) && (bus.op != OP_BOTTOM || i == 0)) begin
                st1_d.al[i] = norm(bus.a_l[i*Q +: Q]);
                st1_d.ar[i] = norm(bus.a_r[i*Q +: Q]);
                st1_d.bl[i] = norm(bus.b_l[i*Q +: Q]);
                st1_d.br[i] = norm(bus.b_r[i*Q +: Q]);
            end
        end
        for (int i = 0; i < P; i++) begin
            if (bus.op == OP_BOTTOM && i == 0) begin
                rs1            = sat_add(st1_d.ar[0], r01_in);
                st1_d.s1[0]    = rs1[Q-1:0];
                st1_d.m[0]     = fmin(st1_d.al[0], r00_in);
                st1_d.sat      = st1_d.sat | rs1[Q];
            end else begin
                rs1            = sat_add(st1_d.ar[i], st1_d.br[i]);
                st1_d.s1[i]    = rs1[Q-1:0];
                st1_d.m[i]     = fmin(st1_d.al[i], st1_d.bl[i]);
                if (bus.op == OP_L_LEFT || bus.op == OP_B_UPDATE) begin
                    st1_d.sat = st1_d.sat | rs1[Q];
                end
            end
        end
    end

    generate
        if (PIPE == 2) begin : g_two_stage
            assign ld1 = !v1 || ld2;

            // Stage-1 register: loads when empty or when stage 2 is taking its content
            always_ff @(posedge clk) begin
                if (rst) begin
                    v1    <= 1'b0;
                    st1_q <= '0;
                end else if (ld1) begin
                    v1 <= bus.in_valid;
                    if (bus.in_valid) begin
                        st1_q <= st1_d;
                    end
                end
            end
        end else begin : g_one_stage
            assign ld1   = ld2;
            assign v1    = bus.in_valid;
            assign st1_q = st1_d;
        end
    endgenerate

    // Stage-2 datapath: final kernels per opcode; u0/u1 hold unless BOTTOM
    always_comb begin
        a_n   = '0;
        b_n   = '0;
        rs2   = '0;
        u0_n  = u0_q;
        u1_n  = u1_q;
        sat_n = st1_q.sat;
        case (st1_q.op)
            OP_L_LEFT: begin
                for (int i = 0; i < P; i++) begin
                    a_n[i] = fmin(st1_q.al[i], st1_q.s1[i]);
                end
            end
            OP_L_RIGHT: begin
                for (int i = 0; i < P; i++) begin
                    rs2    = sat_add(st1_q.m[i], st1_q.ar[i]);
                    a_n[i] = rs2[Q-1:0];
                    sat_n  = sat_n | rs2[Q];
                end
            end
            OP_B_UPDATE: begin
                for (int i = 0; i < P; i++) begin
                    a_n[i] = fmin(st1_q.bl[i], st1_q.s1[i]);
                    rs2    = sat_add(st1_q.m[i], st1_q.br[i]);
                    b_n[i] = rs2[Q-1:0];
                    sat_n  = sat_n | rs2[Q];
                end
            end
            OP_BOTTOM: begin
                // f is symmetric, so f(R00,L10) reuses the stage-1 term f(L10,R00)
                u0_n   = fmin(st1_q.al[0], st1_q.s1[0]);
                rs2    = sat_add(st1_q.m[0], st1_q.ar[0]);
                u1_n   = rs2[Q-1:0];
                sat_n  = sat_n | rs2[Q];
                a_n[0] = fmin(r00_q, st1_q.s1[0]);
                rs2    = sat_add(st1_q.m[0], r01_q);
                b_n[0] = rs2[Q-1:0];
                sat_n  = sat_n | rs2[Q];
            end
            default: begin
                sat_n = 1'b0;
            end
        endcase
    end

    // Output stage register: result and its side-band travel together
    always_ff @(posedge clk) begin
        if (rst) begin
            v2    <= 1'b0;
            o_q   <= '0;
            u0_q  <= '0;
            u1_q  <= '0;
            sat_q <= 1'b0;
            err_q <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                o_q   <= {b_n, a_n};
                u0_q  <= u0_n;
                u1_q  <= u1_n;
                sat_q <= sat_n;
                err_q <= st1_q.op[2];
            end
        end
    end

    // Copy of the last result the consumer accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            o_prev_q <= '0;
        end else if (v2 && bus.out_ready) begin
            o_prev_q <= o_q;
        end
    end

    assign bus.out_valid = v2;
    assign bus.o         = o_q;
    assign bus.o_prev    = o_prev_q;
    assign bus.u0        = u0_q;
    assign bus.u1        = u1_q;
    assign bus.sat_flag  = sat_q;
    assign bus.op_err    = err_q;
endmodule

// File: tb/tb_scan_pe_pipe.sv
// tb/tb_scan_pe_pipe.sv - scoreboard bench for scan_pe_pipe with PIPE=1 and PIPE=2 instances
module tb_scan_pe_pipe;
    localparam int P  = 64;
    localparam int Q  = 6;
    localparam int SW = $clog2($clog2(P) + 1);
    localparam int PQ = P * Q;
    localparam int W  = 2 * PQ;
    localparam int MX = (1 << (Q - 1)) - 1;
    localparam int LOGP = $clog2(P);

    typedef struct {
        logic [W-1:0] o;
        logic [Q-1:0] u0;
        logic [Q-1:0] u1;
        logic         sat;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]    op_d;
    logic [SW-1:0] sl_d;
    logic          f0_d;
    logic          f1_d;
    logic [PQ-1:0] al_d, ar_d, bl_d, br_d;

    int vectors = 0;
    int miscompares = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [W-1:0] prev1, prev2;
    logic [Q-1:0] ul0 [1:2];
    logic [Q-1:0] ul1 [1:2];

    always #5 clk = ~clk;

    scan_pe_pipe_if #(.P(P), .Q(Q), .SW(SW)) if1 ();
    scan_pe_pipe_if #(.P(P), .Q(Q), .SW(SW)) if2 ();

    assign if1.op = op_d;       assign if2.op = op_d;
    assign if1.size_log = sl_d; assign if2.size_log = sl_d;
    assign if1.frozen0 = f0_d;  assign if2.frozen0 = f0_d;
    assign if1.frozen1 = f1_d;  assign if2.frozen1 = f1_d;
    assign if1.a_l = al_d;      assign if2.a_l = al_d;
    assign if1.a_r = ar_d;      assign if2.a_r = ar_d;
    assign if1.b_l = bl_d;      assign if2.b_l = bl_d;
    assign if1.b_r = br_d;      assign if2.b_r = br_d;

    scan_pe_pipe #(.P(P), .Q(Q), .PIPE(1), .SW(SW)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    scan_pe_pipe #(.P(P), .Q(Q), .PIPE(2), .SW(SW)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nrm(input logic [Q-1:0] t);
        int v;
        v = int'($signed(t));
        return (v < -MX) ? -MX : v;
    endfunction

    function automatic int lane(input logic [PQ-1:0] v, input int i);
        logic [Q-1:0] t;
        t = v[i*Q +: Q];
        return nrm(t);
    endfunction

    function automatic int clp(input int v);
        return (v > MX) ? MX : ((v < -MX) ? -MX : v);
    endfunction

    function automatic int fm(input int x, input int y);
        int ax, ay, m;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        m  = (ax < ay) ? ax : ay;
        return ((x < 0) != (y < 0)) ? -m : m;
    endfunction

    function automatic exp_t model(input logic [2:0] opc, input logic [SW-1:0] sl,
                                   input logic f0, input logic f1,
                                   input logic [PQ-1:0] al, input logic [PQ-1:0] ar,
                                   input logic [PQ-1:0] bl, input logic [PQ-1:0] br,
                                   input logic [Q-1:0] pu0, input logic [Q-1:0] pu1);
        exp_t e;
        int n, x, y, z, w, s, t, av, bv, r0, r1, uv0, uv1;
        e.o = '0; e.u0 = pu0; e.u1 = pu1; e.sat = 1'b0; e.err = opc[2];
        n = 1 << ((int'(sl) > LOGP) ? LOGP : int'(sl));
        if (!opc[2]) begin
            for (int i = 0; i < n; i++) begin
                x = lane(al, i); y = lane(ar, i); w = lane(bl, i); z = lane(br, i);
                av = 0; bv = 0;
                case (opc)
                    3'd0: begin
                        t = y + z; if (t > MX || t < -MX) e.sat = 1'b1;
                        av = fm(x, clp(t));
                    end
                    3'd1: begin
                        t = fm(x, w) + y; if (t > MX || t < -MX) e.sat = 1'b1;
                        av = clp(t);
                    end
                    3'd2: begin
                        t = y + z; if (t > MX || t < -MX) e.sat = 1'b1;
                        s = clp(t); av = fm(w, s);
                        t = fm(x, w) + z; if (t > MX || t < -MX) e.sat = 1'b1;
                        bv = clp(t);
                    end
                    default: begin
                        if (i == 0) begin
                            r0 = f0 ? MX : 0; r1 = f1 ? MX : 0;
                            t = y + r1; if (t > MX || t < -MX) e.sat = 1'b1;
                            s = clp(t);
                            uv0 = fm(x, s);
                            t = fm(x, r0) + y; if (t > MX || t < -MX) e.sat = 1'b1;
                            uv1 = clp(t);
                            av = fm(r0, s);
                            t = fm(r0, x) + r1; if (t > MX || t < -MX) e.sat = 1'b1;
                            bv = clp(t);
                            e.u0 = uv0[Q-1:0]; e.u1 = uv1[Q-1:0];
                        end
                    end
                endcase
                e.o[i*Q +: Q]      = av[Q-1:0];
                e.o[PQ + i*Q +: Q] = bv[Q-1:0];
            end
        end
        return e;
    endfunction

    function automatic logic [PQ-1:0] one(input int v);
        logic [PQ-1:0] r;
        r = '0;
        r[Q-1:0] = v[Q-1:0];
        return r;
    endfunction

    function automatic logic [PQ-1:0] fill(input int lo, input int hi, input int split);
        logic [PQ-1:0] r;
        int t;
        for (int i = 0; i < P; i++) begin
            t = (i < split) ? lo : hi;
            r[i*Q +: Q] = t[Q-1:0];
        end
        return r;
    endfunction

    function automatic logic [PQ-1:0] rnd_vec();
        logic [PQ-1:0] r;
        for (int i = 0; i < P; i++) r[i*Q +: Q] = Q'($urandom);
        return r;
    endfunction

    task automatic drive(input int sel, input logic [2:0] opc, input logic [SW-1:0] sl,
                         input logic f0, input logic f1,
                         input logic [PQ-1:0] al, input logic [PQ-1:0] ar,
                         input logic [PQ-1:0] bl, input logic [PQ-1:0] br);
        exp_t e;
        logic ok;
        e = model(opc, sl, f0, f1, al, ar, bl, br, ul0[sel], ul1[sel]);
        op_d = opc; sl_d = sl; f0_d = f0; f1_d = f1;
        al_d = al; ar_d = ar; bl_d = bl; br_d = br;
        if (sel == 1) if1.in_valid = 1'b1; else if2.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = (sel == 1) ? if1.in_ready : if2.in_ready;
            @(posedge clk);
            #1;
        end
        chk("accept", W'(ok), W'(1));
        if (ok) begin
            if (sel == 1) q1.push_back(e); else q2.push_back(e);
            ul0[sel] = e.u0;
            ul1[sel] = e.u1;
        end
        if1.in_valid = 1'b0;
        if2.in_valid = 1'b0;
    endtask

    task automatic cmp_out(input string t, input exp_t e, input logic [W-1:0] o,
                           input logic [Q-1:0] u0, input logic [Q-1:0] u1,
                           input logic s, input logic er);
        chk({t, "_o"}, o, e.o);
        chk({t, "_u0"}, W'(u0), W'(e.u0));
        chk({t, "_u1"}, W'(u1), W'(e.u1));
        chk({t, "_sat"}, W'(s), W'(e.sat));
        chk({t, "_err"}, W'(er), W'(e.err));
    endtask

    // Scoreboard for the single-stage instance
    always @(negedge clk) begin
        if (!rst) begin
            chk("d1_o_prev", if1.o_prev, prev1);
            if (if1.out_valid) begin
                chk("d1_expected_pending", W'(q1.size() != 0), W'(1));
                if (q1.size() != 0) begin
                    cmp_out("d1", q1[0], if1.o, if1.u0, if1.u1, if1.sat_flag, if1.op_err);
                    if (if1.out_ready) begin
                        prev1 = q1[0].o;
                        void'(q1.pop_front());
                    end
                end
            end
        end
    end

    // Scoreboard for the two-stage instance
    always @(negedge clk) begin
        if (!rst) begin
            chk("d2_o_prev", if2.o_prev, prev2);
            if (if2.out_valid) begin
                chk("d2_expected_pending", W'(q2.size() != 0), W'(1));
                if (q2.size() != 0) begin
                    cmp_out("d2", q2[0], if2.o, if2.u0, if2.u1, if2.sat_flag, if2.op_err);
                    if (if2.out_ready) begin
                        prev2 = q2[0].o;
                        void'(q2.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        op_d = '0; sl_d = '0; f0_d = 1'b0; f1_d = 1'b0;
        al_d = '0; ar_d = '0; bl_d = '0; br_d = '0;
        if1.in_valid = 1'b0; if2.in_valid = 1'b0;
        if1.out_ready = 1'b1; if2.out_ready = 1'b1;
        prev1 = '0; prev2 = '0;
        ul0[1] = '0; ul0[2] = '0; ul1[1] = '0; ul1[2] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", W'(if1.out_valid), W'(0));
        chk("rst_in_ready", W'(if2.in_ready), W'(0));
        chk("rst_o", if1.o, '0);
        chk("rst_flags", W'({if1.sat_flag, if1.op_err, if1.u0, if1.u1}), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // L_LEFT lane 0: f(10, sat(-4 + -3)) = -7
        drive(1, 3'd0, SW'(6), 1'b0, 1'b0, one(10), one(-4), '0, one(-3));
        chk("t1_out_valid", W'(if1.out_valid), W'(1));
        chk("t1_lane0", W'(if1.o[Q-1:0]), W'(6'h39));
        chk("t1_sat", W'(if1.sat_flag), W'(0));

        // L_RIGHT saturating, with and without the -2^(Q-1) input
        drive(1, 3'd1, SW'(6), 1'b0, 1'b0, one(-20), one(-20), one(25), '0);
        chk("t2_lane0", W'(if1.o[Q-1:0]), W'(6'h21));
        chk("t2_sat", W'(if1.sat_flag), W'(1));
        drive(1, 3'd1, SW'(6), 1'b0, 1'b0, one(-32), one(-20), one(25), '0);
        chk("t2b_lane0", W'(if1.o[Q-1:0]), W'(6'h21));

        // BOTTOM with noise in the other lanes, then u0/u1 must hold through L_LEFT
        drive(1, 3'd3, SW'(6), 1'b1, 1'b0, {rnd_vec() & ~PQ'(63)} | one(5),
              {rnd_vec() & ~PQ'(63)} | one(-3), rnd_vec(), rnd_vec());
        chk("t3_u0", W'(if1.u0), W'(6'h3d));
        chk("t3_u1", W'(if1.u1), W'(6'h02));
        chk("t3_a0", W'(if1.o[Q-1:0]), W'(6'h3d));
        chk("t3_b0", W'(if1.o[PQ +: Q]), W'(6'h05));
        drive(1, 3'd0, SW'(6), 1'b0, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        chk("t3_u0_hold", W'(if1.u0), W'(6'h3d));

        // Lane masking with size_log=2
        drive(1, 3'd0, SW'(2), 1'b0, 1'b0, fill(31, 31, 4), fill(31, 31, 4), '0, fill(31, 31, 4));
        chk("t5_low", W'(if1.o[4*Q-1:0]), W'({4{6'd31}}));
        chk("t5_high", if1.o, W'({4{6'd31}}));
        chk("t5_sat", W'(if1.sat_flag), W'(1));
        drive(1, 3'd0, SW'(2), 1'b0, 1'b0, fill(5, 31, 4), fill(1, 31, 4), '0, fill(2, 31, 4));
        chk("t5b_sat", W'(if1.sat_flag), W'(0));

        // Reserved opcode
        drive(1, 3'd5, SW'(6), 1'b1, 1'b1, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        chk("t6_err", W'(if1.op_err), W'(1));
        chk("t6_o", if1.o, '0);

        // Random traffic against a randomly stalling consumer
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    @(posedge clk); #2;
                    if1.out_ready = 1'($urandom_range(0, 1));
                end
                if1.out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 20; k++)
            drive(1, 3'($urandom_range(0, 4)), SW'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        for (int k = 0; k < 200 && (q1.size() != 0 || !if1.out_ready); k++) @(posedge clk);
        #1;
        chk("d1_drain", W'(q1.size()), W'(0));

        // Two-stage pipe: four back-to-back ops against a 3-cycle stall
        fork
            begin
                if2.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 if2.out_ready = 1'b1;
            end
        join_none
        drive(2, 3'd0, SW'(6), 1'b0, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        chk("t4_lat1", W'(if2.out_valid), W'(0));
        drive(2, 3'd1, SW'(6), 1'b0, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        chk("t4_lat2", W'(if2.out_valid), W'(1));
        @(negedge clk);
        chk("t4_full_stall", W'(if2.in_ready), W'(0));
        drive(2, 3'd2, SW'(6), 1'b0, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        drive(2, 3'd3, SW'(6), 1'b1, 1'b1, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());

        fork
            begin
                for (int k = 0; k < 50; k++) begin
                    @(posedge clk); #2;
                    if2.out_ready = 1'($urandom_range(0, 1));
                end
                if2.out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 16; k++)
            drive(2, 3'($urandom_range(0, 4)), SW'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        for (int k = 0; k < 200 && (q2.size() != 0 || !if2.out_ready); k++) @(posedge clk);
        #1;
        chk("d2_drain", W'(q2.size()), W'(0));

        // Reset with two operations in flight
        if2.out_ready = 1'b0;
        drive(2, 3'd3, SW'(6), 1'b1, 1'b0, one(7), one(9), '0, '0);
        drive(2, 3'd2, SW'(6), 1'b0, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        rst = 1'b1;
        q1.delete(); q2.delete();
        prev1 = '0; prev2 = '0;
        ul0[1] = '0; ul0[2] = '0; ul1[1] = '0; ul1[2] = '0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_valid", W'(if2.out_valid), W'(0));
        chk("t6_rst_o", if2.o, '0);
        chk("t6_rst_o_prev", if2.o_prev, '0);
        chk("t6_rst_u", W'({if2.u0, if2.u1}), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        if2.out_ready = 1'b1;
        drive(2, 3'd0, SW'(6), 1'b0, 1'b0, one(10), one(-4), '0, one(-3));
        for (int k = 0; k < 20 && q2.size() != 0; k++) @(posedge clk);
        #1;
        chk("t6_fresh_drain", W'(q2.size()), W'(0));
        chk("t6_fresh_prev", W'(if2.o_prev[Q-1:0]), W'(6'h39));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
